// File: rtl/tx_pkg.sv
// tx_pkg: shared types and helpers for the multi-channel TX interrupt manager.
// Holds the FSM state encoding, the width of the optional per-channel
// statistics counters and the index-width helper used to derive CW.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } tx_state_e;

  localparam int STAT_W = 16;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tx_rr_arb.sv
// tx_rr_arb: combinational rotating-priority encoder. Returns the first
// asserted request at or after 'base', wrapping modulo NCH.
module tx_rr_arb
  import tx_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CW  = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  base,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  logic [CW-1:0] idx;

  // scan channels starting at base; the first hit wins
  always_comb begin
    idx     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(base) + i) % NCH);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/tx_irq_mgr.sv
// tx_irq_mgr: multi-channel TX interrupt generator (pcie_clk domain).
// Per-channel data-ready pulses are latched as pending, qualified against the
// channel's hw/sw pointer pair and enable, arbitrated round-robin and issued
// one at a time over a req/ack handshake, followed by a programmable hold-off
// that coalesces bursts.
// Optional feature: define TX_IRQ_STATS_EN to add per-channel saturating
// counters of acknowledged interrupts, readable through stat_sel/stat_cnt.
module tx_irq_mgr
  import tx_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int PW  = 64,
  parameter  int TW  = 16,
  localparam int CW  = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    dta_rdy,
  input  logic [NCH*PW-1:0] hw_ptr,
  input  logic [NCH*PW-1:0] sw_ptr,
  input  logic [NCH-1:0]    irq_en,
  input  logic [TW-1:0]     holdoff,
  output logic              irq_req,
  output logic [CW-1:0]     irq_ch,
  input  logic              irq_ack,
  output logic [NCH-1:0]    pend
`ifdef TX_IRQ_STATS_EN
  ,
  input  logic [CW-1:0]     stat_sel,
  output logic [STAT_W-1:0] stat_cnt
`endif
);

  tx_state_e      state;
  logic [CW-1:0]  rr_ptr;
  logic [TW-1:0]  hold_cnt;
  logic [NCH-1:0] ptr_eq;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] gnt_vec;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_vld;
  logic           grant;
  logic           ack_take;

  // a channel is worth an interrupt only while software lags hardware
  always_comb begin
    ptr_eq = '0;
    for (int k = 0; k < NCH; k++) begin
      ptr_eq[k] = (hw_ptr[k*PW +: PW] == sw_ptr[k*PW +: PW]);
    end
    elig = pend & irq_en & ~ptr_eq;
  end

  tx_rr_arb #(.NCH(NCH)) u_arb (
    .req     (elig),
    .base    (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign grant    = (state == IDLE) && gnt_vld;
  assign ack_take = (state == REQ) && irq_ack;

  // one-hot clear mask for the channel granted this cycle
  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[gnt_idx] = 1'b1;
  end

  // pending bits: a new pulse beats a same-cycle grant or pointer catch-up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= dta_rdy | (pend & ~gnt_vec & ~ptr_eq);
  end

  // request/hold-off sequencer; the request is never retracted once raised
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      irq_req  <= 1'b0;
      irq_ch   <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            irq_ch  <= gnt_idx;
            irq_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_req  <= 1'b0;
            rr_ptr   <= (irq_ch == CW'(NCH - 1)) ? '0 : irq_ch + 1'b1;
            hold_cnt <= holdoff;
            state    <= (holdoff == '0) ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt <= TW'(1)) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TX_IRQ_STATS_EN
  logic [STAT_W-1:0] stat_q [NCH];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // per-channel acknowledged-interrupt counters and registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) stat_q[k] <= '0;
      stat_cnt <= '0;
    end else begin
      if (ack_take) stat_q[irq_ch] <= sat_inc(stat_q[irq_ch]);
      stat_cnt <= (int'(stat_sel) < NCH) ? stat_q[stat_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_tx_irq_mgr.sv
// tb_tx_irq_mgr: directed scenarios followed by randomized traffic, every
// cycle compared against a timestamp-based behavioural model of the manager.
`timescale 1ns/1ps
module tb_tx_irq_mgr;
  import tx_pkg::*;

  localparam int NCH = 4;
  localparam int PW  = 64;
  localparam int TW  = 16;
  localparam int CW  = clog2(NCH);

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    dta_rdy;
  logic [NCH*PW-1:0] hw_ptr;
  logic [NCH*PW-1:0] sw_ptr;
  logic [NCH-1:0]    irq_en;
  logic [TW-1:0]     holdoff;
  logic              irq_req;
  logic [CW-1:0]     irq_ch;
  logic              irq_ack;
  logic [NCH-1:0]    pend;
`ifdef TX_IRQ_STATS_EN
  logic [CW-1:0]     stat_sel;
  logic [STAT_W-1:0] stat_cnt;
`endif

  logic [PW-1:0] hw_a [NCH];
  logic [PW-1:0] sw_a [NCH];

  always #5 clk = ~clk;

  always_comb begin
    hw_ptr = '0;
    sw_ptr = '0;
    for (int k = 0; k < NCH; k++) begin
      hw_ptr[k*PW +: PW] = hw_a[k];
      sw_ptr[k*PW +: PW] = sw_a[k];
    end
  end

  tx_irq_mgr #(.NCH(NCH), .PW(PW), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .dta_rdy  (dta_rdy),
    .hw_ptr   (hw_ptr),
    .sw_ptr   (sw_ptr),
    .irq_en   (irq_en),
    .holdoff  (holdoff),
    .irq_req  (irq_req),
    .irq_ch   (irq_ch),
    .irq_ack  (irq_ack),
    .pend     (pend)
`ifdef TX_IRQ_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: pending set, outstanding request, and the earliest
  // clock edge at which a new grant is allowed after the last ack
  bit [NCH-1:0] m_pend;
  bit           m_req;
  int           m_ch;
  int           m_rr;
  int           m_next_ok;
  int           m_cnt [NCH];
  int           m_stat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_pend    = '0;
    m_req     = 1'b0;
    m_ch      = 0;
    m_rr      = 0;
    m_next_ok = 0;
    m_stat    = 0;
    for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
  endfunction

  function automatic void model_update();
    bit [NCH-1:0] np;
    int g;
    if (!rst) begin
      model_reset();
      return;
    end
    g = -1;
    if (!m_req && cyc >= m_next_ok) begin
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (m_rr + i) % NCH;
        if (g < 0 && m_pend[k] && irq_en[k] && (hw_a[k] != sw_a[k])) g = k;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (dta_rdy[k])              np[k] = 1'b1;
      else if (k == g)             np[k] = 1'b0;
      else if (hw_a[k] == sw_a[k]) np[k] = 1'b0;
      else                         np[k] = m_pend[k];
    end
`ifdef TX_IRQ_STATS_EN
    m_stat = (int'(stat_sel) < NCH) ? m_cnt[stat_sel] : 0;
    if (m_req && irq_ack && m_cnt[m_ch] < 65535) m_cnt[m_ch]++;
`endif
    if (m_req && irq_ack) begin
      m_req     = 1'b0;
      m_rr      = (m_ch + 1) % NCH;
      m_next_ok = cyc + 1 + int'(holdoff);
    end else if (g >= 0) begin
      m_req = 1'b1;
      m_ch  = g;
    end
    m_pend = np;
  endfunction

  task automatic compare_all();
    chk("irq_req", 64'(irq_req), 64'(m_req));
    if (m_req) chk("irq_ch", 64'(irq_ch), 64'(m_ch));
    chk("pend", 64'(pend), 64'(m_pend));
`ifdef TX_IRQ_STATS_EN
    chk("stat_cnt", 64'(stat_cnt), 64'(m_stat));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    compare_all();
  endtask

  task automatic wait_req(input string tag, input int max);
    int n;
    n = 0;
    while (!irq_req && n < max) begin
      step();
      n++;
    end
    chk(tag, 64'(irq_req), 64'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_q[$];
    int exp_rr[3];
    bit prev;
    int rises;
    int rise_cyc;
    int ack_cyc;

    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 3;
    rst = 1'b0; dta_rdy = '0; irq_en = '1; irq_ack = 1'b0; holdoff = '0;
    for (int k = 0; k < NCH; k++) begin hw_a[k] = '0; sw_a[k] = '0; end
`ifdef TX_IRQ_STATS_EN
    stat_sel = '0;
`endif
    model_reset();
    repeat (3) step();
    chk("rst_req", 64'(irq_req), 64'd0);
    chk("rst_ch", 64'(irq_ch), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    rst = 1'b1;

    // single channel, immediate latency
    hw_a[2] = 64'h10; sw_a[2] = 64'h08;
    dta_rdy = 4'b0100; step(); dta_rdy = '0;
    chk("s1_pend2", 64'(pend[2]), 64'd1);
    step();
    chk("s1_req", 64'(irq_req), 64'd1);
    chk("s1_ch", 64'(irq_ch), 64'd2);
    repeat (3) step();
    chk("s1_held", 64'(irq_req), 64'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("s1_drop", 64'(irq_req), 64'd0);
    chk("s1_pend2_clr", 64'(pend[2]), 64'd0);
    sw_a[2] = 64'h10;

    // equal pointers: no interrupt, pending auto-clears
    hw_a[1] = 64'h40; sw_a[1] = 64'h40;
    dta_rdy = 4'b0010; step(); dta_rdy = '0;
    chk("s2_pend1", 64'(pend[1]), 64'd1);
    step();
    chk("s2_autoclr", 64'(pend[1]), 64'd0);
    chk("s2_noreq", 64'(irq_req), 64'd0);
    sw_a[1] = 64'h3F;
    dta_rdy = 4'b0010; step(); dta_rdy = '0; step();
    chk("s2_req", 64'(irq_req), 64'd1);
    chk("s2_ch", 64'(irq_ch), 64'd1);

    // asynchronous reset while a request is outstanding
    dta_rdy = 4'b1000; step(); dta_rdy = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("ar_req", 64'(irq_req), 64'd0);
    chk("ar_pend", 64'(pend), 64'd0);
    repeat (2) step();
    rst = 1'b1;
`ifdef TX_IRQ_STATS_EN
    step();
    chk("ar_stat", 64'(stat_cnt), 64'd0);
`endif

    // round robin over channels 0, 1, 3 with immediate acks, twice
    hw_a[0] = 64'h1; sw_a[0] = 64'h0;
    hw_a[3] = 64'h5; sw_a[3] = 64'h0;
    irq_ack = 1'b1;
    for (int r = 0; r < 2; r++) begin
      dta_rdy = 4'b1011; step(); dta_rdy = '0;
      got_q.delete();
      prev = 1'b0;
      for (int n = 0; n < 12; n++) begin
        step();
        if (irq_req && !prev) got_q.push_back(int'(irq_ch));
        prev = irq_req;
      end
      chk("rr_count", 64'(got_q.size()), 64'd3);
      for (int i = 0; i < 3 && i < got_q.size(); i++) chk("rr_seq", 64'(got_q[i]), 64'(exp_rr[i]));
    end
    irq_ack = 1'b0;

    // coalescing with a 10-cycle hold-off
    sw_a[1] = hw_a[1]; sw_a[3] = hw_a[3];
    holdoff = 16'd10;
    dta_rdy = 4'b0001; step(); dta_rdy = '0;
    wait_req("co_first_req", 5);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    ack_cyc = cyc;
    rises = 0; rise_cyc = -1; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      dta_rdy = (i < 10 && (i % 2) == 0) ? 4'b0001 : 4'b0000;
      irq_ack = irq_req;
      step();
      // cycle in which the new request is first visible
      if (irq_req && !prev) begin
        rises++;
        if (rise_cyc < 0) rise_cyc = cyc + 1;
      end
      prev = irq_req;
    end
    dta_rdy = '0; irq_ack = 1'b0;
    chk("co_rises", 64'(rises), 64'd1);
    chk("co_gap", 64'(rise_cyc - ack_cyc), 64'd12);

    // pulse coinciding with grant, and enable dropped during a request
    holdoff = '0;
    dta_rdy = 4'b0001; step();
    step(); dta_rdy = '0;
    chk("sim_req", 64'(irq_req), 64'd1);
    chk("sim_ch", 64'(irq_ch), 64'd0);
    chk("sim_pend0", 64'(pend[0]), 64'd1);
    irq_en[0] = 1'b0;
    repeat (3) step();
    chk("en_hold_req", 64'(irq_req), 64'd1);
    chk("en_hold_ch", 64'(irq_ch), 64'd0);
    irq_en[0] = 1'b1;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("sim_drop", 64'(irq_req), 64'd0);
    step();
    chk("sim_second", 64'(irq_req), 64'd1);
    chk("sim_second_ch", 64'(irq_ch), 64'd0);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 15) == 0) hw_a[k] = PW'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) sw_a[k] = PW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 99) == 0) irq_en = NCH'($urandom);
      if ($urandom_range(0, 49) == 0) holdoff = TW'($urandom_range(0, 6));
      dta_rdy = NCH'($urandom & $urandom);
      irq_ack = 1'($urandom_range(0, 1));
`ifdef TX_IRQ_STATS_EN
      stat_sel = CW'($urandom_range(0, NCH - 1));
`endif
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        chk("rnd_ar_req", 64'(irq_req), 64'd0);
        chk("rnd_ar_pend", 64'(pend), 64'd0);
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
